// File: rtl/memctl_pkg.sv
// Shared types and helpers for the round-robin shared-RAM arbiter.
// Holds default geometry, the read-return pipeline entry and the address translation.
package memctl_pkg;

    localparam int NUM_CORES_DEF = 8;
    localparam int AW_DEF        = 12;
    localparam int DW_DEF        = 16;
    localparam int MAW_DEF       = 15;
    localparam int PRIV_BASE_DEF = 3500;
    localparam int MEM_LAT_DEF   = 1;

    // Wide enough for the largest supported core count (16).
    localparam int ID_W = 4;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            err;
    } rd_ent_t;

    typedef struct packed {
        logic [31:0] phys;
        logic        ovf;
    } xlate_t;

    // Private region is interleaved so word n of core k lands at base + n*cores + k.
    function automatic xlate_t xlate_addr(
        input logic [31:0] addr,
        input logic [31:0] priv_base,
        input logic [31:0] num_cores,
        input logic [31:0] core_id,
        input int unsigned maw
    );
        logic [63:0] p;
        xlate_t      r;
        if (addr < priv_base) begin
            p = {32'd0, addr};
        end else begin
            p = {32'd0, priv_base} + ({32'd0, addr - priv_base} * {32'd0, num_cores})
                + {32'd0, core_id};
        end
        r.phys = p[31:0];
        r.ovf  = (p >> maw) != 64'd0;
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_rr_arbiter.sv
// Work-conserving round-robin arbiter: search starts at the pointer and wraps;
// the pointer moves just past each winner so a granted core queues behind the others.
module rr_arbiter #(
    parameter int NUM_CORES = 8
) (
    input  logic                 clk16,
    input  logic                 rstn,
    input  logic [NUM_CORES-1:0] req,
    output logic [NUM_CORES-1:0] gnt,
    output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] gnt_id,
    output logic                 gnt_vld
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [IW-1:0]        ptr;
    logic [NUM_CORES-1:0] gnt_raw;
    logic [IW-1:0]        win_id;
    logic                 found;
    logic [IW-1:0]        idx;

    always_comb begin
        gnt_raw = '0;
        win_id  = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_CORES);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt_raw[idx] = 1'b1;
                win_id       = idx;
            end
        end
    end

    assign gnt     = rstn ? gnt_raw : '0;
    assign gnt_vld = found & rstn;
    assign gnt_id  = win_id;

    always_ff @(posedge clk16 or negedge rstn) begin
        if (!rstn) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (win_id == IW'(NUM_CORES - 1)) ? '0 : win_id + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of NUM_CORES core ports onto one single-port synchronous RAM,
// with private-region interleaving and per-core read return.
module mem_arbiter_rr
    import memctl_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAW       = MAW_DEF,
    parameter int PRIV_BASE = PRIV_BASE_DEF,
    parameter int MEM_LAT   = MEM_LAT_DEF
) (
    input  logic                    clk16,
    input  logic                    rstn,
    input  logic [NUM_CORES-1:0]    req,
    input  logic [NUM_CORES-1:0]    we,
    input  logic [NUM_CORES*AW-1:0] addr,
    input  logic [NUM_CORES*DW-1:0] wdata,
    output logic [NUM_CORES-1:0]    gnt,
    output logic [NUM_CORES-1:0]    rvalid,
    output logic [NUM_CORES*DW-1:0] rdata,
    output logic [NUM_CORES-1:0]    addr_err,
    output logic [MAW-1:0]          mem_addr,
    output logic                    mem_we,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [IW-1:0] gnt_id;
    logic          gnt_vld;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_arb (
        .clk16   (clk16),
        .rstn    (rstn),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic [DW-1:0] sel_wdata;
    xlate_t        xl;
    logic          ovf;

    always_comb begin
        sel_addr  = addr[int'(gnt_id)*AW +: AW];
        sel_we    = we[gnt_id];
        sel_wdata = wdata[int'(gnt_id)*DW +: DW];
        xl        = xlate_addr(32'(sel_addr), 32'(PRIV_BASE), 32'(NUM_CORES), 32'(gnt_id), MAW);
        ovf       = xl.ovf | (|(xl.phys >> MAW));
    end

    // Stage p0: RAM command and read-tracking entry, valid in the cycle after the grant.
    rd_ent_t rd_pipe [0:MEM_LAT];

    always_ff @(posedge clk16 or negedge rstn) begin
        if (!rstn) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            addr_err  <= '0;
            for (int j = 0; j <= MEM_LAT; j++) begin
                rd_pipe[j] <= '0;
            end
        end else begin
            addr_err <= '0;
            if (gnt_vld) begin
                mem_addr  <= xl.phys[MAW-1:0];
                mem_we    <= sel_we & ~ovf;
                mem_wdata <= sel_wdata;
                if (ovf) begin
                    addr_err[gnt_id] <= 1'b1;
                end
            end else begin
                mem_we <= 1'b0;
            end
            rd_pipe[0].valid <= gnt_vld & ~sel_we;
            rd_pipe[0].id    <= ID_W'(gnt_id);
            rd_pipe[0].err   <= ovf;
            for (int j = 1; j <= MEM_LAT; j++) begin
                rd_pipe[j] <= rd_pipe[j-1];
            end
        end
    end

    // Stage p(MEM_LAT): RAM data is valid now; dropped reads return zero.
    logic          ret_vld;
    logic [IW-1:0] ret_id;
    logic [DW-1:0] ret_data;
    logic [DW-1:0] rdata_q [NUM_CORES];

    assign ret_vld  = rd_pipe[MEM_LAT].valid;
    assign ret_id   = rd_pipe[MEM_LAT].id[IW-1:0];
    assign ret_data = rd_pipe[MEM_LAT].err ? '0 : mem_rdata;

    always_comb begin
        rvalid = '0;
        if (ret_vld) begin
            rvalid[ret_id] = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            rdata[k*DW +: DW] = rvalid[k] ? ret_data : rdata_q[k];
        end
    end

    always_ff @(posedge clk16 or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                rdata_q[k] <= '0;
            end
        end else if (ret_vld) begin
            rdata_q[ret_id] <= ret_data;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr: stimulus queues expected grants, RAM commands
// and read returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_arbiter_rr;

    localparam int N   = 8;
    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int MAW = 15;

    logic clk16 = 1'b0;
    logic rstn;
    always #5 clk16 = ~clk16;

    logic [N-1:0]    req, we, gnt, rvalid, addr_err;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata, rdata;
    logic [MAW-1:0]  mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    logic [N-1:0]    req_b, we_b, gnt_b, rvalid_b, addr_err_b;
    logic [N*AW-1:0] addr_b;
    logic [N*DW-1:0] wdata_b, rdata_b;
    logic [11:0]     mem_addr_b;
    logic            mem_we_b;
    logic [DW-1:0]   mem_wdata_b, mem_rdata_b;
    assign mem_rdata_b = 16'hA5A5;

    mem_arbiter_rr u_dut (
        .clk16(clk16), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .addr_err(addr_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter_rr #(.MAW(12)) u_dut_b (
        .clk16(clk16), .rstn(rstn), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
        .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .addr_err(addr_err_b),
        .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    // RAM model with one cycle of read latency, plus a preload port.
    logic [DW-1:0]  ram [0:(1<<MAW)-1];
    logic           pre_we;
    logic [MAW-1:0] pre_addr;
    logic [DW-1:0]  pre_data;
    always @(posedge clk16) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk16) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int a; bit w; int d; } acc_t;
    typedef struct { int k; int d; int c; } rd_t;
    int   exp_gnt [$];
    acc_t exp_acc [$];
    rd_t  exp_rd  [$];

    logic [N-1:0] gnt_prev = '0;
    int   gi;
    acc_t ea;
    rd_t  er;

    always @(negedge clk16) begin
        if (gnt != '0) begin
            chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
            gi = 0;
            for (int k = 0; k < N; k++) if (gnt[k]) gi = k;
            if (exp_gnt.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL gnt_unexpected: got core %0d, expected none", gi);
            end else begin
                chk("gnt_order", gi, exp_gnt.pop_front());
            end
        end
        if (gnt_prev != '0) begin
            if (exp_acc.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL acc_unexpected: got mem_addr %0d, expected none", mem_addr);
            end else begin
                ea = exp_acc.pop_front();
                chk("mem_addr", 32'(mem_addr), ea.a);
                chk("mem_we", 32'(mem_we), 32'(ea.w));
                if (ea.w) chk("mem_wdata", 32'(mem_wdata), ea.d);
            end
        end
        gnt_prev <= gnt;
        for (int k = 0; k < N; k++) begin
            if (rvalid[k]) begin
                if (exp_rd.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rvalid_unexpected: got rvalid on core %0d, expected none", k);
                end else begin
                    er = exp_rd.pop_front();
                    chk("rd_core", k, er.k);
                    chk("rd_data", 32'(rdata[k*DW +: DW]), er.d);
                    chk("rd_cycle", cyc, er.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic preload(input int a, input int d);
        pre_addr = MAW'(a); pre_data = DW'(d); pre_we = 1'b1;
        @(posedge clk16); #1;
        pre_we = 1'b0;
    endtask

    // Holds req for core k until granted; returns the grant cycle.
    task automatic issue(input int k, input bit w, input int a, input int d, output int t);
        req[k] = 1'b1; we[k] = w;
        addr[k*AW +: AW] = AW'(a); wdata[k*DW +: DW] = DW'(d);
        t = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk16);
            if (gnt[k]) begin t = cyc; break; end
        end
        if (t < 0) begin
            n_checks++; n_fail++;
            $display("FAIL grant_timeout: core %0d got no grant, expected one within 20 cycles", k);
        end
        @(posedge clk16); #1;
        req[k] = 1'b0; we[k] = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_rvalid"}, 32'(rvalid), 0);
        chk({tag, "_rdata"}, 32'(|rdata), 0);
        chk({tag, "_addr_err"}, 32'(addr_err), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_ptr"}, 32'(u_dut.u_arb.ptr), 0);
    endtask

    int t;

    initial begin
        rstn = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0; pre_we = 1'b0;
        pre_addr = '0; pre_data = '0;
        preload(100, 16'hBEEF);
        preload(10, 16'h1010);
        preload(11, 16'h1111);
        preload(3520, 16'h4444);
        @(negedge clk16);
        chk_all_zero("reset");
        @(posedge clk16); #1;
        rstn = 1'b1;

        // Core 2 reads 100.
        exp_gnt.push_back(2); exp_acc.push_back('{a:100, w:0, d:0});
        issue(2, 0, 100, 0, t);
        exp_rd.push_back('{k:2, d:16'hBEEF, c:t+2});
        chk("ptr_after_c2", 32'(u_dut.u_arb.ptr), 3);

        // Private region: core 3 write/read, core 4 read of the same core address.
        exp_gnt.push_back(3); exp_acc.push_back('{a:3519, w:1, d:16'h1234});
        issue(3, 1, 3502, 16'h1234, t);
        exp_gnt.push_back(3); exp_acc.push_back('{a:3519, w:0, d:0});
        issue(3, 0, 3502, 0, t);
        exp_rd.push_back('{k:3, d:16'h1234, c:t+2});
        exp_gnt.push_back(4); exp_acc.push_back('{a:3520, w:0, d:0});
        issue(4, 0, 3502, 0, t);
        exp_rd.push_back('{k:4, d:16'h4444, c:t+2});

        exp_gnt.push_back(5); exp_acc.push_back('{a:300, w:1, d:16'h0505});
        issue(5, 1, 300, 16'h0505, t);
        chk("ptr_before_pair", 32'(u_dut.u_arb.ptr), 6);

        // Cores 1 and 5 contend with pointer at 6: wrap puts core 1 first.
        t = cyc;
        exp_gnt.push_back(1); exp_gnt.push_back(5);
        exp_acc.push_back('{a:10, w:0, d:0}); exp_acc.push_back('{a:11, w:0, d:0});
        exp_rd.push_back('{k:1, d:16'h1010, c:t+2});
        exp_rd.push_back('{k:5, d:16'h1111, c:t+3});
        addr[1*AW +: AW] = 12'd10; addr[5*AW +: AW] = 12'd11;
        req[1] = 1'b1; req[5] = 1'b1;
        @(posedge clk16); #1;
        chk("ptr_after_c1", 32'(u_dut.u_arb.ptr), 2);
        req[1] = 1'b0;
        @(posedge clk16); #1;
        chk("ptr_after_c5", 32'(u_dut.u_arb.ptr), 6);
        req[5] = 1'b0;

        exp_gnt.push_back(7); exp_acc.push_back('{a:301, w:1, d:16'h0707});
        issue(7, 1, 301, 16'h0707, t);
        chk("ptr_wrap", 32'(u_dut.u_arb.ptr), 0);

        // All cores hold req for 16 cycles: two full rotations, no gaps.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) begin
                exp_gnt.push_back(k);
                exp_acc.push_back('{a:200+k, w:1, d:k});
            end
        end
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW] = AW'(200 + k); wdata[k*DW +: DW] = DW'(k);
        end
        req = '1; we = '1;
        repeat (16) @(posedge clk16);
        #1;
        req = '0; we = '0;

        // MAW=12 instance: core 7 at 4000 translates past 4095.
        req_b[7] = 1'b1; we_b[7] = 1'b1;
        addr_b[7*AW +: AW] = 12'd4000; wdata_b[7*DW +: DW] = 16'h7777;
        @(negedge clk16);
        chk("b_gnt_wr", 32'(gnt_b), 32'h80);
        @(posedge clk16); #1;
        req_b = '0; we_b = '0;
        @(negedge clk16);
        chk("b_mem_we_dropped", 32'(mem_we_b), 0);
        chk("b_addr_err_wr", 32'(addr_err_b), 32'h80);
        @(negedge clk16);
        chk("b_addr_err_once", 32'(addr_err_b), 0);
        chk("b_no_rvalid_wr", 32'(rvalid_b), 0);
        @(posedge clk16); #1;
        req_b[7] = 1'b1;
        @(negedge clk16);
        chk("b_gnt_rd", 32'(gnt_b), 32'h80);
        @(posedge clk16); #1;
        req_b = '0;
        @(negedge clk16);
        chk("b_addr_err_rd", 32'(addr_err_b), 32'h80);
        chk("b_rvalid_early", 32'(rvalid_b), 0);
        @(negedge clk16);
        chk("b_rvalid", 32'(rvalid_b), 32'h80);
        chk("b_rdata_zero", 32'(rdata_b[7*DW +: DW]), 0);
        @(negedge clk16);
        chk("b_rvalid_pulse", 32'(rvalid_b), 0);

        // Reset while a read from core 0 is in flight.
        @(posedge clk16); #1;
        exp_gnt.push_back(0); exp_acc.push_back('{a:50, w:0, d:0});
        issue(0, 0, 50, 0, t);
        @(negedge clk16); #1;
        rstn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge clk16);
        chk("midrst_rvalid_hold", 32'(rvalid), 0);
        @(posedge clk16); #1;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk16);
            chk("post_rst_rvalid", 32'(rvalid), 0);
        end

        repeat (3) @(negedge clk16);
        chk("gnt_queue_empty", exp_gnt.size(), 0);
        chk("acc_queue_empty", exp_acc.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised successor to the fixed 8-slot TDM memory controller.
- Arbitrates NUM_CORES core ports onto one single-port synchronous RAM using a work-conserving round-robin req/gnt handshake instead of fixed time slots.
- Translates per-core private-region addresses into an interleaved physical layout.
- Returns read data with a per-core valid pulse.
- Sits between the core array and the shared data/instruction RAM.

Parameters:
- NUM_CORES, 8, number of requesting cores (2..16)
- AW, 12, core-side address width
- DW, 16, data width
- MAW, 15, memory-side address width
- PRIV_BASE, 3500, first core address of the per-core private region
- MEM_LAT, 1, RAM read latency in cycles, from registered mem_addr to valid mem_rdata (1..4)

Ports:
- clk16  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req  in  NUM_CORES  per-core access request, held until granted
- we  in  NUM_CORES  per-core write enable, qualifies req
- addr  in  NUM_CORES*AW  flattened core addresses, core i at [i*AW +: AW]
- wdata  in  NUM_CORES*DW  flattened write data
- gnt  out  NUM_CORES  one-hot grant (combinational)
- rvalid  out  NUM_CORES  read-data valid pulse per core
- rdata  out  NUM_CORES*DW  flattened per-core read data
- addr_err  out  NUM_CORES  pulse: translated address overflowed MAW
- mem_addr  out  MAW  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data

Behaviour:
- Reset (rstn low, async): gnt=0, rvalid=0, rdata=0, addr_err=0, mem_we=0, mem_addr=0, mem_wdata=0, rr pointer=0, read pipeline cleared.
- Reset mid-operation: in-flight reads are discarded and never produce rvalid.
- Arbitration: search req starting at pointer, wrapping modulo NUM_CORES; the first set bit wins. gnt is one-hot, or zero when req==0. Handshake completes in any cycle where req[i]&gnt[i].
- Pointer update: on each grant to core k, the pointer becomes (k+1) mod NUM_CORES. No grant leaves the pointer unchanged.
- Address translation, zero-extended arithmetic:
  - addr < PRIV_BASE: phys = addr.
  - addr >= PRIV_BASE: phys = PRIV_BASE + (addr-PRIV_BASE)*NUM_CORES + k.
- Overflow: if phys >= 2^MAW, the access is dropped. mem_we is forced 0, addr_err[k] pulses in cycle T+1, and a read still returns rvalid with rdata=0 at its normal time.
- Issue: grant in cycle T registers mem_addr/mem_we/mem_wdata, valid during T+1.
- Idle: with no grant, mem_we=0 next cycle and mem_addr/mem_wdata hold their values.
- Read return:
  - A shift pipeline of depth MEM_LAT+1 carries {valid, core id, err}.
  - rvalid[k] pulses for exactly one cycle at T+1+MEM_LAT, with rdata[k] captured from mem_rdata.
  - rdata[k] holds until the next read by core k.
- Writes produce no rvalid.
- Throughput: one access per cycle sustained. Back-to-back reads from different cores return in grant order.
- A core may re-request in the cycle after its grant, but waits behind other requesters (fairness). Worst-case wait is NUM_CORES-1 grants.
- Simultaneous events: when a new grant and a return for the same core fall in the same cycle, both proceed independently.

Decomposition:
- Package memctl_pkg: default NUM_CORES, AW, DW, MAW, PRIV_BASE; the function computing physical address and overflow flag; the read-pipeline entry struct {valid, id, err}.
- Sub-module rr_arbiter (NUM_CORES param): req in, pointer state, one-hot gnt, encoded grant id.
- Translation and return pipeline stay in the top level.

Test Plan:
- Reset, then core 2 reads addr 100 with RAM[100]=0xBEEF -> gnt[2] in T, mem_addr=100 at T+1, rvalid[2] and rdata[2]=0xBEEF at T+2; all other rvalid stay 0.
- All 8 cores hold req continuously for 16 cycles -> grants 0,1,...,7,0,...,7, one per cycle, no gaps.
- Core 3 writes 0x1234 to addr 3502 -> mem_we=1, mem_addr=3519. Core 3 then reads addr 3502 -> rdata[3]=0x1234. Core 4 reads addr 3502 -> mem_addr=3520.
- Cores 1 and 5 request while pointer=6 -> core 1 granted first, then core 5; pointer becomes 2 after core 1's grant and 6 after core 5's.
- MAW=12 build, core 7 writes addr 4000 -> translated 3500+500*8+7 overflows; mem_we=0, addr_err[7] pulses once. A read of the same address -> rvalid[7] with rdata=0.
- Core 0 read granted, then rstn asserted low before its return cycle -> no rvalid[0] after reset release, and all outputs are 0 during reset.
